hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
- Sequencer that owns all writes into the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the EX stage and runs a counted multiply or a 32-iteration radix-2 divide.
- Stalls the pipeline while an operation is in flight, then emits a single write_hilo_en pulse with the HI/LO data.
- Sits between EX and the HILO register file; a flush from the exception logic cancels an in-flight operation.

Parameters:
- MUL_CYCLES, 4, number of MUL-state cycles before the multiply result is written (1..15).
- DIV_ITERS, 32, divide iterations; fixed for 32-bit operands.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (RST_ENABLE = 1'b0)
- start  in  1  EX requests an op; held high until done
- op  in  3  MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5
- operand_a  in  32  rs value (multiplicand / dividend / MT source)
- operand_b  in  32  rt value (multiplier / divisor)
- flush  in  1  cancel current op, no HI/LO write
- read_hi_data  in  32  current HI (from HILO read port)
- read_lo_data  in  32  current LO
- stall_req  out  1  pipeline stall request
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle completion strobe
- write_hilo_en  out  1  HILO write enable
- write_hi_data  out  32  value written to HI
- write_lo_data  out  32  value written to LO

Behaviour:
- Reset (rst == 0 at posedge): state=IDLE, counter=0, operand/partial registers cleared. All outputs are 0 while rst is low.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start=1, MTHI/MTLO:
  - Handled combinationally the same cycle; no stall; stays IDLE.
  - done=1, write_hilo_en=1.
  - MTHI: hi=operand_a, lo=read_lo_data. MTLO: hi=read_hi_data, lo=operand_a.
- IDLE, start=1, MULT/MULTU:
  - Latch operands and signedness; go to MUL.
- IDLE, start=1, DIV/DIVU, operand_b != 0:
  - Latch |a|, |b| (abs only if signed); record quotient and remainder signs; go to DIV.
- IDLE, start=1, DIV/DIVU, operand_b == 0:
  - Go directly to DONE with hi=operand_a, lo=32'hFFFF_FFFF.
- MUL: counter counts 1..MUL_CYCLES, then DONE. Product is the full 64-bit signed (MULT) or unsigned (MULTU) product; hi=product[63:32], lo=product[31:0].
- DIV: one restoring shift-subtract step per cycle for DIV_ITERS cycles, then DONE.
- DONE:
  - Final fixup: quotient negated if operand signs differed (signed only); remainder takes the dividend sign.
  - Outputs hi=remainder, lo=quotient.
  - write_hilo_en=1, done=1 for exactly one cycle; next state IDLE.
- Latency from accept cycle 0: MULT/MULTU writes in cycle MUL_CYCLES+1 (5 by default). DIV/DIVU writes in cycle 33. Divide-by-zero writes in cycle 1.
- stall_req = start & ~done & ~flush (combinational). It is also 1 in the accept cycle of a multi-cycle op.
- busy = (state != IDLE).
- start is ignored outside IDLE; op and operands are used only at accept.
- After DONE, start low in the next cycle. start high in the next cycle is a new operation.
- flush=1 in any state: next state IDLE, and write_hilo_en/done forced to 0 that cycle, including in DONE and for MTHI/MTLO in IDLE.
- Precedence: rst over flush over everything else.
- Signed overflow case 0x8000_0000 / -1: lo=0x8000_0000, hi=0 (natural two's-complement result; no trap).

Decomposition:
- global_def additions: MD_* op encodings, MD_OP_BUS width (2:0), state encodings, DIV_ITERS.
- Sub-module div_core: iterative radix-2 restoring divider with start/iterate/finish controls, 32-bit quotient and remainder registers, and the sign fixup. Controller keeps the FSM, multiply path and output muxing.

Test Plan:
- MULT a=0xFFFF_FFFE (-2), b=3: stall_req high cycles 0..4; cycle 5 write_hilo_en=1, hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF: cycle 5 writes hi=0xFFFF_FFFE, lo=0x0000_0001.
- DIV a=-7, b=2: cycle 33 writes lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1). DIVU a=100, b=7: lo=14, hi=2.
- DIVU b=0, a=0x1234: cycle 1 writes hi=0x1234, lo=0xFFFF_FFFF. MTHI a=0xCAFE with read_lo_data=0x55: same-cycle write hi=0xCAFE, lo=0x55, stall_req=0.
- DIV started, flush=1 at cycle 10: no write_hilo_en ever, busy=0 at cycle 11. A new MULT accepted at cycle 11 completes normally.
- rst=0 at cycle 20 of a DIV: outputs all 0 next cycle, state IDLE; no HI/LO write after rst releases.

Source files
------------

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: op codes,
// FSM states, result-source selector and a small magnitude helper.
package hilo_muldiv_ctrl_pkg;

  localparam int XLEN      = 32;
  localparam int MD_OP_W   = 3;   // MD_OP_BUS is [2:0]
  localparam int DIV_ITERS = 32;  // one quotient bit per iteration
  localparam int CNT_W     = 6;   // wide enough for DIV_ITERS and MUL_CYCLES

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Which datapath feeds HI/LO when the FSM reaches DONE.
  typedef enum logic [1:0] {
    RES_MUL  = 2'd0,
    RES_DIV  = 2'd1,
    RES_DIVZ = 2'd2
  } md_res_e;

  // Two's-complement magnitude, applied only for signed operations.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_core.sv
// Iterative radix-2 restoring divider. Load captures operand magnitudes and
// result signs, each step retires one quotient bit, and the outputs carry the
// sign-corrected quotient and remainder.
module hilo_muldiv_ctrl_div_core
  import hilo_muldiv_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_signed,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  logic [XLEN-1:0] r_quo;   // dividend shifts out the top, quotient bits in the bottom
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_den;
  logic            r_q_neg;
  logic            r_r_neg;

  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_fits;

  // Partial remainder shifted left by one with the next dividend bit appended.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_den};
  assign w_fits  = ~w_diff[XLEN];

  // Load operands or retire one quotient bit per cycle.
  always_ff @(posedge clk) begin
    // NOTE: every datapath register is reset, not only the control state, so no X ever reaches HI/LO after reset.
    if (!rst) begin
      r_quo   <= '0;
      r_rem   <= '0;
      r_den   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else if (i_load) begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values, so ordering here is irrelevant.
      r_quo   <= mag(i_dividend, i_signed);
      r_den   <= mag(i_divisor, i_signed);
      r_rem   <= '0;
      r_q_neg <= i_signed & (i_dividend[XLEN-1] ^ i_divisor[XLEN-1]);
      r_r_neg <= i_signed & i_dividend[XLEN-1];
    end else if (i_step) begin
      r_rem <= w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      r_quo <= {r_quo[XLEN-2:0], w_fits};
    end
  end

  // Quotient negative when operand signs differ; remainder follows the dividend.
  assign o_quotient  = r_q_neg ? (~r_quo + 1'b1) : r_quo;
  assign o_remainder = r_r_neg ? (~r_rem + 1'b1) : r_rem;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO write sequencer: accepts mult/div/move-to requests from EX, stalls the
// pipe while a multi-cycle op runs, and emits one write_hilo_en pulse with data.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [XLEN-1:0]    operand_a,
  input  logic [XLEN-1:0]    operand_b,
  input  logic               flush,
  input  logic [XLEN-1:0]    read_hi_data,
  input  logic [XLEN-1:0]    read_lo_data,
  output logic               stall_req,
  output logic               busy,
  output logic               done,
  output logic               write_hilo_en,
  output logic [XLEN-1:0]    write_hi_data,
  output logic [XLEN-1:0]    write_lo_data
);

  md_state_e        r_state;
  md_res_e          r_res;
  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0]  r_op_a;
  logic [XLEN-1:0]  r_op_b;
  logic             r_signed;

  md_op_e           w_op;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_is_mt;
  logic             w_idle_go;
  logic             w_div_load;
  logic             w_div_step;
  logic [2*XLEN-1:0] w_mul_a;
  logic [2*XLEN-1:0] w_mul_b;
  logic [2*XLEN-1:0] w_product;
  logic [XLEN-1:0]  w_quotient;
  logic [XLEN-1:0]  w_remainder;

  assign w_op      = md_op_e'(op);
  assign w_is_mul  = (w_op == MD_MULT) || (w_op == MD_MULTU);
  assign w_is_div  = (w_op == MD_DIV)  || (w_op == MD_DIVU);
  assign w_is_mt   = (w_op == MD_MTHI) || (w_op == MD_MTLO);
  assign w_idle_go = rst & ~flush & start & (r_state == ST_IDLE);

  assign w_div_load = w_idle_go & w_is_div & (operand_b != '0);
  assign w_div_step = (r_state == ST_DIV);

  // Sign-extending to 64 bits makes the low 64 bits of an unsigned multiply
  // equal the signed product, so one multiplier covers MULT and MULTU.
  assign w_mul_a   = {{XLEN{r_signed & r_op_a[XLEN-1]}}, r_op_a};
  assign w_mul_b   = {{XLEN{r_signed & r_op_b[XLEN-1]}}, r_op_b};
  assign w_product = w_mul_a * w_mul_b;

  hilo_muldiv_ctrl_div_core u_div_core (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_div_load),
    .i_step      (w_div_step),
    .i_signed    (w_op == MD_DIV),
    .i_dividend  (operand_a),
    .i_divisor   (operand_b),
    .o_quotient  (w_quotient),
    .o_remainder (w_remainder)
  );

  // Control FSM: accept in IDLE, count MUL/DIV cycles, then one DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_res    <= RES_MUL;
      r_count  <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_signed <= 1'b0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_count <= '0;
          if (start && w_is_mul) begin
            r_op_a   <= operand_a;
            r_op_b   <= operand_b;
            r_signed <= (w_op == MD_MULT);
            r_res    <= RES_MUL;
            r_state  <= ST_MUL;
          end else if (start && w_is_div) begin
            r_op_a   <= operand_a;
            r_op_b   <= operand_b;
            r_signed <= (w_op == MD_DIV);
            if (operand_b == '0) begin
              r_res   <= RES_DIVZ;
              r_state <= ST_DONE;
            end else begin
              r_res   <= RES_DIV;
              r_state <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          r_count <= r_count + 1'b1;
          if (r_count == CNT_W'(MUL_CYCLES - 1)) r_state <= ST_DONE;
        end
        ST_DIV: begin
          r_count <= r_count + 1'b1;
          if (r_count == CNT_W'(DIV_ITERS - 1)) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_count <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Write strobe and HI/LO data; move-to ops complete in the same IDLE cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    done          = 1'b0;
    write_hilo_en = 1'b0;
    write_hi_data = '0;
    write_lo_data = '0;
    if (rst && !flush) begin
      if (r_state == ST_IDLE && start && w_is_mt) begin
        done          = 1'b1;
        write_hilo_en = 1'b1;
        if (w_op == MD_MTHI) begin
          write_hi_data = operand_a;
          write_lo_data = read_lo_data;
        end else begin
          write_hi_data = read_hi_data;
          write_lo_data = operand_a;
        end
      end else if (r_state == ST_DONE) begin
        done          = 1'b1;
        write_hilo_en = 1'b1;
        case (r_res)
          RES_MUL: begin
            write_hi_data = w_product[2*XLEN-1:XLEN];
            write_lo_data = w_product[XLEN-1:0];
          end
          RES_DIVZ: begin
            write_hi_data = r_op_a;
            write_lo_data = '1;
          end
          default: begin
            write_hi_data = w_remainder;
            write_lo_data = w_quotient;
          end
        endcase
      end
    end
  end

  assign stall_req = rst & start & ~done & ~flush;
  assign busy      = rst & (r_state != ST_IDLE);

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: latency, HI/LO values, stall, flush
// and reset behaviour checked against hand-computed vectors.
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic [31:0] read_hi_data;
  logic [31:0] read_lo_data;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic        write_hilo_en;
  logic [31:0] write_hi_data;
  logic [31:0] write_lo_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl #(.MUL_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .op            (op),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .flush         (flush),
    .read_hi_data  (read_hi_data),
    .read_lo_data  (read_lo_data),
    .stall_req     (stall_req),
    .busy          (busy),
    .done          (done),
    .write_hilo_en (write_hilo_en),
    .write_hi_data (write_hi_data),
    .write_lo_data (write_lo_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one op at cycle 0 and expect exactly one write at exp_cyc.
  task automatic run_op(input string tag, input md_op_e o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int  cyc;
    bit  seen;
    bit  stall_ok;
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    cyc = 0; seen = 0; stall_ok = 1;
    while (!seen && cyc <= 60) begin
      @(negedge clk);
      if (write_hilo_en) begin
        seen = 1;
        check({tag, " cycle"}, cyc, exp_cyc);
        check({tag, " hi"}, write_hi_data, exp_hi);
        check({tag, " lo"}, write_lo_data, exp_lo);
        check({tag, " done"}, done, 1'b1);
        check({tag, " stall at write"}, stall_req, 1'b0);
      end else if (!stall_req) begin
        stall_ok = 0;
      end
      next_cycle();
      // Operands only matter at accept; scramble them afterwards.
      if (cyc == 0) begin
        operand_a = 32'h0BAD_F00D;
        operand_b = 32'h0;
        op        = MD_MTHI;
      end
      cyc++;
    end
    start = 1'b0;
    check({tag, " write seen"}, seen, 1'b1);
    check({tag, " stall before write"}, stall_ok, 1'b1);
    @(negedge clk);
    check({tag, " idle after"}, {busy, write_hilo_en}, 2'b00);
    next_cycle();
  endtask

  // Issue one op and raise flush at cycle fc; no write may ever appear.
  task automatic run_flush(input string tag, input md_op_e o, input logic [31:0] a,
                           input logic [31:0] b, input int fc);
    bit no_wr;
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    no_wr = 1;
    for (int c = 0; c <= fc; c++) begin
      if (c == fc) flush = 1'b1;
      @(negedge clk);
      if (write_hilo_en || done) no_wr = 0;
      if (c == fc) check({tag, " stall in flush"}, stall_req, 1'b0);
      next_cycle();
    end
    flush = 1'b0;
    start = 1'b0;
    check({tag, " no write"}, no_wr, 1'b1);
    check({tag, " busy after flush"}, busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit no_wr;
    rst = 1'b0; start = 1'b1; op = MD_MTHI; operand_a = 32'h5; operand_b = 32'h0;
    flush = 1'b0; read_hi_data = 32'h1111_2222; read_lo_data = 32'h3333_4444;

    // Outputs forced low while reset is held, even with a move-to request.
    @(negedge clk);
    check("reset ctrl outs", {stall_req, busy, done, write_hilo_en}, 4'b0000);
    check("reset data outs", {write_hi_data, write_lo_data}, 64'h0);
    next_cycle();
    next_cycle();
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    check("idle after reset", {busy, done, write_hilo_en}, 3'b000);
    next_cycle();

    run_op("MULT -2*3",        MD_MULT,  32'hFFFF_FFFE, 32'h3,          5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("MULTU max*max",    MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  5,  32'hFFFF_FFFE, 32'h0000_0001);
    run_op("MULT 7fff*-1",     MD_MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF,  5,  32'hFFFF_FFFF, 32'h8000_0001);
    run_op("DIV -7/2",         MD_DIV,   32'hFFFF_FFF9, 32'h2,          33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("DIV 7/-2",         MD_DIV,   32'h7,         32'hFFFF_FFFE,  33, 32'h1,         32'hFFFF_FFFD);
    run_op("DIVU 100/7",       MD_DIVU,  32'd100,       32'd7,          33, 32'd2,         32'd14);
    run_op("DIVU ffffffff/10", MD_DIVU,  32'hFFFF_FFFF, 32'h10,         33, 32'hF,         32'h0FFF_FFFF);
    run_op("DIV min/-1",       MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  33, 32'h0,         32'h8000_0000);
    run_op("DIVU 1234/0",      MD_DIVU,  32'h1234,      32'h0,          1,  32'h1234,      32'hFFFF_FFFF);
    run_op("DIV -5/0",         MD_DIV,   32'hFFFF_FFFB, 32'h0,          1,  32'hFFFF_FFFB, 32'hFFFF_FFFF);

    read_lo_data = 32'h55;
    run_op("MTHI cafe",        MD_MTHI,  32'hCAFE,      32'h0,          0,  32'hCAFE,      32'h55);
    read_hi_data = 32'h77;
    run_op("MTLO beef",        MD_MTLO,  32'hBEEF,      32'h0,          0,  32'h77,        32'hBEEF);

    // Flush mid-divide, then a new multiply is accepted the very next cycle.
    run_flush("flush DIV@10", MD_DIV, 32'd100, 32'd3, 10);
    run_op("MULT after flush", MD_MULT, 32'd6, 32'd7, 5, 32'h0, 32'd42);

    // Flush landing on the DONE cycle and on a same-cycle move-to.
    run_flush("flush MULT@DONE", MD_MULTU, 32'd9, 32'd9, 5);
    run_flush("flush MTHI", MD_MTHI, 32'h1234_5678, 32'h0, 0);

    // Reset mid-divide: outputs zero while held, no stray write afterwards.
    start = 1'b1; op = MD_DIVU; operand_a = 32'd1000; operand_b = 32'd3;
    for (int c = 0; c <= 20; c++) begin
      if (c == 20) rst = 1'b0;
      @(negedge clk);
      if (c == 20) begin
        check("rst mid-DIV ctrl outs", {stall_req, busy, done, write_hilo_en}, 4'b0000);
        check("rst mid-DIV data outs", {write_hi_data, write_lo_data}, 64'h0);
      end
      next_cycle();
    end
    rst = 1'b1; start = 1'b0;
    check("busy after rst", busy, 1'b0);
    no_wr = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (write_hilo_en || busy) no_wr = 0;
      next_cycle();
    end
    check("no write after rst", no_wr, 1'b1);

    run_op("DIVU 1000/3 post-rst", MD_DIVU, 32'd1000, 32'd3, 33, 32'd1, 32'd333);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
